fifo_bit_serializer: RTL and testbench



---
 rtl/fifo_ser_pkg.sv | 15 +
 rtl/fifo_bit_serializer.sv | 103 ++++++++++
 tb/tb_fifo_bit_serializer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ser_pkg.sv
// rtl/fifo_ser_pkg.sv - shared state encoding and sizing helper for the bit serializer
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  // Bit-index width; never below 1 so the counter always exists.
  function automatic int bcnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fifo_bit_serializer.sv
// rtl/fifo_bit_serializer.sv - parallel word to 1-bit FIFO pusher with optional even parity
module fifo_bit_serializer
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             enq,
  output logic             din,
  input  logic             full,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BCNT_W = bcnt_w(WIDTH);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

  ser_state_e        state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              par_q, par_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bcnt_d   = bcnt_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    enq      = 1'b0;
    din      = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_d  = in_data;
          bcnt_d  = '0;
          par_d   = ^in_data;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        din = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
        // full freezes every register so the same bit is re-offered next cycle.
        if (!full) begin
          enq    = 1'b1;
          sreg_d = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};
          bcnt_d = bcnt_q + BCNT_W'(1);
          if (bcnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PAR;
            end else begin
              state_d = IDLE;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      PAR: begin
        din = par_q;
        if (!full) begin
          enq     = 1'b1;
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_bit_serializer.sv
// tb/tb_fifo_bit_serializer.sv - self-checking bench for three serializer configurations
module tb_fifo_bit_serializer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_a, rst_bc;
  logic        valid    [3];
  logic [7:0]  data     [3];
  logic        full_drv [3];
  logic        full_w   [3];
  logic        use_fifo;
  logic [1:0]  fifo_cnt;
  logic [2:0]  rdy, enq, din, busy;
  logic [15:0] wc [3];

  int n_total = 0;
  int n_pass  = 0;

  // DUT 0 can be fed from a two-entry FIFO occupancy model instead of a forced flag.
  always_comb begin
    full_w[0] = use_fifo ? (fifo_cnt == 2'd2) : full_drv[0];
    full_w[1] = full_drv[1];
    full_w[2] = full_drv[2];
  end

  always @(posedge CLK) begin
    if (!use_fifo) fifo_cnt <= 2'd0;
    else if (enq[0]) fifo_cnt <= fifo_cnt + 2'd1;
  end

  fifo_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST_N(rst_a), .in_valid(valid[0]), .in_ready(rdy[0]), .in_data(data[0]),
    .enq(enq[0]), .din(din[0]), .full(full_w[0]), .busy(busy[0]), .word_count(wc[0]));

  fifo_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST_N(rst_bc), .in_valid(valid[1]), .in_ready(rdy[1]), .in_data(data[1]),
    .enq(enq[1]), .din(din[1]), .full(full_w[1]), .busy(busy[1]), .word_count(wc[1]));

  fifo_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1), .CNT_W(16)) dut_c (
    .CLK(CLK), .RST_N(rst_bc), .in_valid(valid[2]), .in_ready(rdy[2]), .in_data(data[2]),
    .enq(enq[2]), .din(din[2]), .full(full_w[2]), .busy(busy[2]), .word_count(wc[2]));

  function automatic logic rstv(input int i);
    return (i == 0) ? rst_a : rst_bc;
  endfunction

  function automatic bit msb_of(input int i);
    return i != 1;
  endfunction

  function automatic bit par_of(input int i);
    return i == 2;
  endfunction

  // Bits in transmission order, index 0 first; parity is from the count of ones.
  function automatic logic [15:0] seq(input logic [7:0] d, input bit msb, input bit p);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s[k] = msb ? d[7-k] : d[k];
    if (p) s[8] = (($countones(d) % 2) == 1);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Model: a list of bits still owed to the FIFO plus a completed-word counter.
  logic [15:0] mbits [3];
  int          mlen  [3];
  logic [15:0] mcnt  [3];

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstv(i)) begin
        mbits[i] <= '0;
        mlen[i]  <= 0;
        mcnt[i]  <= '0;
      end else if (mlen[i] == 0) begin
        if (valid[i]) begin
          mbits[i] <= seq(data[i], msb_of(i), par_of(i));
          mlen[i]  <= 8 + int'(par_of(i));
        end
      end else if (!full_w[i]) begin
        mbits[i] <= mbits[i] >> 1;
        mlen[i]  <= mlen[i] - 1;
        if (mlen[i] == 1) mcnt[i] <= mcnt[i] + 16'd1;
      end
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      logic        idle;
      logic [19:0] expv, actv;
      idle = !rstv(i) || (mlen[i] == 0);
      expv = {idle, !idle && !full_w[i], idle ? 1'b0 : mbits[i][0], !idle,
              rstv(i) ? mcnt[i] : 16'h0};
      actv = {rdy[i], enq[i], din[i], busy[i], wc[i]};
      check($sformatf("cycle_dut%0d", i), 32'(actv), 32'(expv));
    end
  end

  logic [15:0] cap  [3];
  int          ncap [3];

  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (rstv(i) && enq[i]) begin
        cap[i]  <= {cap[i][14:0], din[i]};
        ncap[i] <= ncap[i] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("wait_idle_dut%0d", i), 32'(busy[i]), 32'h0);
  endtask

  task automatic wait_bits(input int i, input int n0, input int k);
    int n;
    n = 0;
    while ((ncap[i] - n0) < k && n < 60) begin
      tick();
      n++;
    end
    check($sformatf("wait_bits_dut%0d", i), 32'(ncap[i] - n0), 32'(k));
  endtask

  task automatic send(input int i, input logic [7:0] d);
    wait_idle(i);
    valid[i] = 1'b1;
    data[i]  = d;
    tick();
    valid[i] = 1'b0;
  endtask

  initial begin
    int n0, nb;
    rst_a = 1'b0;
    rst_bc = 1'b0;
    use_fifo = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      data[i] = 8'h00;
      full_drv[i] = 1'b0;
      cap[i] = '0;
      ncap[i] = 0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_outs_dut%0d", i), 32'({rdy[i], enq[i], din[i], busy[i]}), 32'h8);
      check($sformatf("reset_count_dut%0d", i), 32'(wc[i]), 32'h0);
    end
    rst_a = 1'b1;
    rst_bc = 1'b1;
    tick();

    n0 = ncap[0];
    send(0, 8'hA5);
    wait_bits(0, n0, 3);
    rst_a = 1'b0;
    #1;
    check("midword_reset_outs", 32'({rdy[0], enq[0], din[0]}), 32'h4);
    check("midword_reset_count", 32'(wc[0]), 32'h0);
    tick();
    tick();
    rst_a = 1'b1;
    tick();

    n0 = ncap[0];
    send(0, 8'hB4);
    nb = 0;
    while (busy[0] && nb < 40) begin
      nb++;
      tick();
    end
    check("b4_busy_cycles", 32'(nb), 32'd8);
    check("b4_enq_pulses", 32'(ncap[0] - n0), 32'd8);
    check("b4_bits", 32'(cap[0][7:0]), 32'hB4);
    check("b4_count", 32'(wc[0]), 32'd1);

    n0 = ncap[0];
    send(0, 8'hB4);
    wait_bits(0, n0, 2);
    full_drv[0] = 1'b1;
    #1;
    check("stall_outs", 32'({enq[0], din[0]}), 32'h1);
    tick();
    tick();
    tick();
    full_drv[0] = 1'b0;
    wait_idle(0);
    check("stall_enq_pulses", 32'(ncap[0] - n0), 32'd8);
    check("stall_bits", 32'(cap[0][7:0]), 32'hB4);
    check("stall_count", 32'(wc[0]), 32'd2);

    use_fifo = 1'b1;
    tick();
    n0 = ncap[0];
    send(0, 8'hFF);
    repeat (15) tick();
    check("fifo_pushes", 32'(ncap[0] - n0), 32'd2);
    check("fifo_blocked", 32'({enq[0], busy[0]}), 32'h1);
    check("fifo_count", 32'(wc[0]), 32'd2);
    rst_a = 1'b0;
    tick();
    use_fifo = 1'b0;
    rst_a = 1'b1;
    tick();

    n0 = ncap[1];
    send(1, 8'h01);
    wait_idle(1);
    check("lsb_enq_pulses", 32'(ncap[1] - n0), 32'd8);
    check("lsb_bits", 32'(cap[1][7:0]), 32'h80);
    check("lsb_count", 32'(wc[1]), 32'd1);

    n0 = ncap[2];
    send(2, 8'h07);
    wait_idle(2);
    check("par07_enq_pulses", 32'(ncap[2] - n0), 32'd9);
    check("par07_bits", 32'(cap[2][8:0]), 32'h00F);
    n0 = ncap[2];
    send(2, 8'h03);
    wait_idle(2);
    check("par03_enq_pulses", 32'(ncap[2] - n0), 32'd9);
    check("par03_bits", 32'(cap[2][8:0]), 32'h006);
    check("par_count", 32'(wc[2]), 32'd2);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
